mac_accum_drain: RTL and testbench
==================================

MAC_ACCUM_DRAIN -- requirements
Module: mac_accum_drain

Interface
- REQ-001: Parameter MAC_LATENCY, default 2, clock cycles from operands presented to the MAC until its result is valid; legal range 1-8.
- REQ-002: Parameter ACC_W, default 32, width of the MAC result, the accumulator and the output sum.
- REQ-003: Parameter FIFO_DEPTH, default 4, number of output-buffer entries; must be a power of two and at least 2.
- REQ-004: clock0  input  1  sole clock; all state changes on its rising edge.
- REQ-005: resetn  input  1  asynchronous, active-low reset.
- REQ-006: in_valid  input  1  a beat of operands is presented to the MAC this cycle.
- REQ-007: in_last  input  1  this beat is the final beat of a dot product; qualified by in_valid.
- REQ-008: in_ready  output  1  the block accepts the beat; a beat is accepted when in_valid and in_ready are both 1.
- REQ-009: mac_result  input  ACC_W  signed MAC output, sampled MAC_LATENCY cycles after beat acceptance.
- REQ-010: out_valid  output  1  out_sum holds a completed dot product.
- REQ-011: out_ready  input  1  the consumer takes the head entry; a pop occurs when out_valid and out_ready are both 1.
- REQ-012: out_sum  output  ACC_W  signed saturated dot-product sum.
- REQ-013: out_ovf  output  1  sticky flag: saturation occurred during this dot product.

Function
- REQ-014: Accepted beats shall enter a MAC_LATENCY-deep valid/last shift pipeline; an aligned beat shall be the pipeline output MAC_LATENCY cycles after acceptance.
- REQ-015: State machine states: IDLE and ACCUM.
  - IDLE: accumulator = 0, ovf = 0.
  - IDLE to ACCUM: on an aligned beat with last = 0.
  - ACCUM stays in ACCUM: on an aligned beat with last = 0.
  - ACCUM or IDLE to IDLE: on an aligned beat with last = 1.
- REQ-016: On every aligned beat, next sum = accumulator + mac_result, computed at ACC_W+1 bits and saturated to ACC_W-bit signed max/min.
- REQ-017: When saturation occurs, ovf shall be set; ovf stays set until the dot product completes.
- REQ-018: On an aligned last beat, the block shall write the saturated sum and ovf (including this beat) to the FIFO tail on that edge.
  - On the same edge, the accumulator and ovf shall return to 0.
  - A single-beat dot product (last on the first beat) shall be legal.
- REQ-019: out_valid shall be 1 exactly when the FIFO is non-empty; out_sum and out_ovf shall show the head entry, registered, and stay stable while out_valid = 1 and out_ready = 0.
- REQ-020: The latency from an aligned last beat to out_valid with an empty FIFO shall be 1 cycle.
  - Total latency from acceptance of the last beat to out_valid = MAC_LATENCY + 1.
- REQ-021: pending shall count accepted last beats not yet written to the FIFO.
  - Increment on acceptance of a last beat.
  - Decrement on an aligned-last write.
  - Unchanged when both happen in the same cycle.
- REQ-022: in_ready shall be 1 if and only if (fifo_count + pending) < FIFO_DEPTH, so an aligned write never finds the FIFO full.
  - in_ready shall not depend combinationally on in_valid.
- REQ-023: Push and pop in the same cycle shall be permitted at any occupancy, including full; fifo_count is then unchanged.
- REQ-024: FIFO pointers shall wrap modulo FIFO_DEPTH with no loss or duplication.
- REQ-025: A pop on an empty FIFO shall be impossible, because out_valid = 0.
- REQ-026: Non-last beats shall never be blocked by a full FIFO alone, only by the REQ-022 condition.
- REQ-027: in_valid = 0 cycles between beats of one dot product shall be legal; they create bubbles and the accumulator holds its value.

Reset
- REQ-028: While resetn = 0, the block shall hold these values:
  - state IDLE, accumulator 0, ovf 0, pending 0, FIFO empty;
  - shift pipeline cleared;
  - out_valid = 0, out_sum = 0, out_ovf = 0, in_ready = 0.
- REQ-029: in_ready shall become 1 on the first rising edge after resetn deasserts.
- REQ-030: Reset asserted mid-dot-product or mid-pipeline shall discard all in-flight beats and partial sums; no output shall appear after release.

Verification
- REQ-031: 4 beats, last on beat 4, each beat mac_result = 3 (all operands 0x01), out_ready = 1 -> one output out_sum = 12, out_ovf = 0, out_valid asserted MAC_LATENCY+1 cycles after beat 4.
- REQ-032: Single beat, last = 1, mac_result = -5 -> out_sum = 0xFFFFFFFB, out_ovf = 0.
- REQ-033: 2 beats of mac_result = 0x7FFFFFF0, then a last beat with mac_result = -16 -> out_sum = 0x7FFFFFEF, out_ovf = 1.
- REQ-034: out_ready = 0, issue back-to-back single-beat products -> in_ready drops after 4 last beats are accepted and stays 0; then out_ready = 1 -> 4 pops in order, in_ready returns to 1.
- REQ-035: Continuous single-beat products with out_ready = 1 -> one output per cycle, sustained push and pop at full, no drops.
- REQ-036: Pulse resetn = 0 for 1 cycle after 2 beats of a 3-beat product, then send a fresh 1-beat product of 7 -> only out_sum = 7 appears.

Source files
------------

// File: rtl/mac_accum_drain.sv
`default_nettype none
// ============================================================================
// Module   : mac_accum_drain
// Brief    : Aligns a pipelined MAC result with its beat and accumulates it with
//            saturation. Completed dot products drain through a credit-guarded
//            output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module mac_accum_drain #(
    parameter int MAC_LATENCY = 2,
    parameter int ACC_W       = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clock0,
    input  logic                    resetn,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] mac_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_ovf
);
    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW:0] c_depth = (c_CW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

    state_t                   r_state, w_state_next;
    logic [MAC_LATENCY-1:0]   r_pv, r_pl;
    logic signed [ACC_W-1:0]  r_acc, w_acc_next, w_acc_op, w_sat_sum;
    logic                     r_ovf, w_ovf_next, w_ovf_new, w_sat;
    logic signed [ACC_W:0]    w_wide;
    logic                     w_accept, w_aligned, w_push, w_pop;
    logic [ACC_W:0]           w_push_data;
    logic [ACC_W:0]           r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]          r_wr_ptr, r_rd_ptr, w_rd_next;
    logic [c_CW-1:0]          r_count, w_count_next, w_after_pop;
    logic [c_CW-1:0]          r_pend, w_pend_next;
    logic                     r_in_ready;
    logic signed [ACC_W-1:0]  r_out_sum;
    logic                     r_out_ovf;

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != '0);
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;

    assign w_accept  = in_valid & r_in_ready;
    assign w_aligned = r_pv[MAC_LATENCY-1];
    assign w_push    = w_aligned & r_pl[MAC_LATENCY-1];
    assign w_pop     = out_valid & out_ready;

    // valid/last travel alongside the operands so the beat lines up with mac_result
    generate
        if (MAC_LATENCY == 1) begin : g_pipe_one
            always_ff @(posedge clock0 or negedge resetn) begin
                if (!resetn) begin
                    r_pv <= '0;
                    r_pl <= '0;
                end else begin
                    r_pv <= w_accept;
                    r_pl <= w_accept & in_last;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clock0 or negedge resetn) begin
                if (!resetn) begin
                    r_pv <= '0;
                    r_pl <= '0;
                end else begin
                    r_pv <= {r_pv[MAC_LATENCY-2:0], w_accept};
                    r_pl <= {r_pl[MAC_LATENCY-2:0], w_accept & in_last};
                end
            end
        end
    endgenerate

    assign w_acc_op  = (r_state == S_IDLE) ? '0 : r_acc;
    assign w_wide    = {w_acc_op[ACC_W-1], w_acc_op} + {mac_result[ACC_W-1], mac_result};
    assign w_sat     = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    assign w_sat_sum = !w_sat ? w_wide[ACC_W-1:0]
                     : (w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
    assign w_ovf_new   = ((r_state == S_IDLE) ? 1'b0 : r_ovf) | w_sat;
    assign w_push_data = {w_ovf_new, w_sat_sum};

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_ovf_next   = r_ovf;
        if (w_aligned) begin
            if (r_pl[MAC_LATENCY-1]) begin
                w_state_next = S_IDLE;
                w_acc_next   = '0;
                w_ovf_next   = 1'b0;
            end else begin
                w_state_next = S_ACCUM;
                w_acc_next   = w_sat_sum;
                w_ovf_next   = w_ovf_new;
            end
        end
    end

    always_ff @(posedge clock0 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_ovf   <= w_ovf_next;
        end
    end

    always_comb begin
        w_pend_next = r_pend;
        if ((w_accept & in_last) && !w_push)
            w_pend_next = r_pend + c_CW'(1);
        else if (!(w_accept & in_last) && w_push)
            w_pend_next = r_pend - c_CW'(1);
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + c_CW'(1);
        else if (!w_push && w_pop)
            w_count_next = r_count - c_CW'(1);
    end

    assign w_rd_next   = w_pop ? r_rd_ptr + c_AW'(1) : r_rd_ptr;
    assign w_after_pop = w_pop ? r_count - c_CW'(1) : r_count;

    always_ff @(posedge clock0) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    // Head register bypasses the RAM when the incoming entry becomes the head
    always_ff @(posedge clock0 or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            r_in_ready <= 1'b0;
            r_out_sum  <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            r_rd_ptr   <= w_rd_next;
            r_count    <= w_count_next;
            r_pend     <= w_pend_next;
            r_in_ready <= (({1'b0, w_count_next} + {1'b0, w_pend_next}) < c_depth);
            if (w_count_next != '0) begin
                if (w_after_pop == '0)
                    {r_out_ovf, r_out_sum} <= w_push_data;
                else
                    {r_out_ovf, r_out_sum} <= r_mem[w_rd_next];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mac_accum_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accum_drain
// Brief    : Directed self-checking bench for mac_accum_drain with a delay-line
//            MAC stand-in driving mac_result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_accum_drain;
    localparam int L = 2;

    logic clock0 = 1'b0, resetn = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_ovf;
    logic signed [31:0] mac_result, out_sum;
    logic signed [31:0] beat_val = '0;
    logic signed [31:0] mpipe [L];

    int cyc = 0, n_pass = 0, n_chk = 0, n_acc_last = 0, acc_edge = 0;
    logic [31:0] q_sum [$];
    logic        q_ovf [$];
    int          q_cyc [$];

    mac_accum_drain #(.MAC_LATENCY(L), .ACC_W(32), .FIFO_DEPTH(4)) dut (
        .clock0(clock0), .resetn(resetn), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .mac_result(mac_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    always #5 clock0 = ~clock0;

    assign mac_result = mpipe[L-1];

    always @(posedge clock0) begin
        cyc      <= cyc + 1;
        mpipe[0] <= (in_valid && in_ready) ? beat_val : 32'shDEADBEEF;
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        if (in_valid && in_ready && in_last) n_acc_last <= n_acc_last + 1;
        if (out_valid && out_ready && resetn) begin
            q_sum.push_back(out_sum);
            q_ovf.push_back(out_ovf);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [31:0] v, input logic last);
        int n = 0;
        @(negedge clock0);
        while (!in_ready && n < 100) begin
            in_valid = 1'b0;
            @(negedge clock0);
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", in_ready, 1'b1);
        in_valid = 1'b1;
        in_last  = last;
        beat_val = v;
        @(posedge clock0);
        #1;
    endtask

    task automatic idle();
        @(negedge clock0);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic clear_q();
        q_sum.delete();
        q_ovf.delete();
        q_cyc.delete();
    endtask

    task automatic wait_pops(input string tag, input int n);
        int k = 0;
        while (q_sum.size() < n && k < 60) begin
            @(negedge clock0);
            k++;
        end
        repeat (5) @(negedge clock0);
        chk(tag, q_sum.size(), n);
    endtask

    task automatic one_result(input string tag, input logic [31:0] s, input logic o);
        wait_pops({tag, "_count"}, 1);
        chk({tag, "_sum"}, q_sum[0], s);
        chk({tag, "_ovf"}, {31'd0, q_ovf[0]}, {31'd0, o});
    endtask

    initial begin
        int base, gaps;
        // Reset state
        repeat (3) @(negedge clock0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum",   out_sum, 32'd0);
        chk("rst_out_ovf",   {31'd0, out_ovf}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        resetn = 1'b1;
        @(posedge clock0);
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Four beats of 3 with a bubble mid-product
        out_ready = 1'b1;
        clear_q();
        send(3, 1'b0); send(3, 1'b0);
        idle(); idle();
        send(3, 1'b0); send(3, 1'b1);
        acc_edge = cyc - 1;
        idle();
        one_result("dot4", 32'd12, 1'b0);
        chk("dot4_latency", q_cyc[0] - acc_edge, L + 1);

        // Positive saturation, sticky through a recovering last beat
        clear_q();
        send(32'h7FFFFFF0, 1'b0); send(32'h7FFFFFF0, 1'b0); send(32'hFFFFFFF0, 1'b1);
        idle();
        one_result("possat", 32'h7FFFFFEF, 1'b1);

        // Negative saturation on the last beat
        clear_q();
        send(32'h80000000, 1'b0); send(32'hFFFFFFFF, 1'b1);
        idle();
        one_result("negsat", 32'h80000000, 1'b1);

        // Single-beat product; ovf must not leak from the previous product
        clear_q();
        send(32'hFFFFFFFB, 1'b1);
        idle();
        one_result("single", 32'hFFFFFFFB, 1'b0);

        // Back-pressure: fill with out_ready low
        clear_q();
        out_ready = 1'b0;
        base = n_acc_last;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock0);
            in_valid = 1'b1;
            in_last  = 1'b1;
            beat_val = 10 + (n_acc_last - base);
        end
        idle();
        chk("bp_accepted", n_acc_last - base, 4);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (4) @(negedge clock0);
        chk("bp_still_low", {31'd0, in_ready}, 32'd0);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_head_stable", out_sum, 32'd10);
        out_ready = 1'b1;
        wait_pops("bp_pops", 4);
        for (int k = 0; k < 4; k++) chk("bp_order", q_sum[k], 10 + k);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);

        // Streaming single-beat products
        clear_q();
        for (int k = 0; k < 12; k++) send(100 + k, 1'b1);
        idle();
        wait_pops("stream_count", 12);
        gaps = 0;
        for (int k = 0; k < 12; k++) begin
            chk("stream_value", q_sum[k], 100 + k);
            if (k > 0 && q_cyc[k] != q_cyc[k-1] + 1) gaps++;
        end
        chk("stream_gaps", gaps, 0);

        // Reset mid-product discards partial sum
        clear_q();
        send(5, 1'b0); send(5, 1'b0);
        idle();
        repeat (3) @(negedge clock0);
        resetn = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock0);
        resetn = 1'b1;
        send(7, 1'b1);
        idle();
        one_result("after_rst", 32'd7, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
